// File: rtl/ahbl_sram64_slave.sv
// Purpose : AHB-lite slave for one 64-bit slot in front of a 1-cycle-latency single-port SRAM,
//           with a one-entry posted write buffer and read forwarding from that buffer.
// Latency : read/write data phase = 1+WAIT_STATES cycles; buffered writes drain in the next free cycle.
// Backpres: HREADYOUT low for wait states, plus one cycle when a write finds the buffer full behind a read.
//
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HWRITE/    AHB-lite address phase (qualified by HREADY)
//   HSIZE/HREADY
//   HWDATA                       write data (data phase)
//   HREADYOUT/HRDATA/HRESP       slave response (HRESP always OKAY)
//   mem_en/mem_we/mem_addr/      SRAM command port (one access per cycle)
//   mem_wbe/mem_wdata
//   mem_rdata                    SRAM read data, valid the cycle after a read strobe
module ahbl_sram64_slave #(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [63:0]   HWDATA,
  output logic          HREADYOUT,
  output logic [63:0]   HRDATA,
  output logic          HRESP,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wbe,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  // Transfer in data phase
  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_lanes;   // byte lanes are derived from HSIZE/HADDR at accept time
  logic [2:0]    r_wcnt;

  // Posted write buffer
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_addr;
  logic [7:0]    r_buf_wbe;
  logic [63:0]   r_buf_data;

  logic [63:0]   r_hrdata;

  logic          w_accept;
  logic          w_rd_accept;
  logic          w_rd_pending;
  logic          w_final;
  logic          w_stall;
  logic          w_ready;
  logic          w_drain;
  logic          w_capture;
  logic          w_first_rd;
  logic          w_fwd_hit;
  logic [7:0]    w_lanes;
  logic [63:0]   w_merged;
  logic [AW-1:0] w_haddr_word;
  logic          w_unused;

  // Upper address bits alias; HTRANS[0] (SEQ vs NONSEQ) makes no difference here.
  assign w_unused     = &{1'b0, HTRANS[0], HADDR[31:AW+3], HADDR[2:0] == 3'd0};
  assign w_haddr_word = HADDR[AW+2:3];

  always_comb begin
    w_lanes = 8'hFF;
    case (HSIZE)
      3'd0:    w_lanes = 8'h01 << HADDR[2:0];
      3'd1:    w_lanes = 8'h03 << {HADDR[2:1], 1'b0};
      3'd2:    w_lanes = HADDR[2] ? 8'hF0 : 8'h0F;
      default: w_lanes = 8'hFF;
    endcase
  end

  assign w_final = (r_state != S_IDLE) && (r_wcnt == LP_WS);

  // A read waiting in the address phase is detected without HREADY, so the
  // full-buffer stall does not form a combinational loop through the decoder.
  assign w_rd_pending = HSEL & HTRANS[1] & ~HWRITE;
  assign w_stall      = (r_state == S_WR) & w_final & r_buf_vld & w_rd_pending;
  assign w_ready      = (r_state == S_IDLE) | (w_final & ~w_stall);

  assign w_accept    = HSEL & HREADY & HTRANS[1] & ~HRESET;
  assign w_rd_accept = w_accept & ~HWRITE;
  assign w_drain     = r_buf_vld & ~w_rd_accept;
  assign w_capture   = (r_state == S_WR) & w_final & ~w_stall;
  assign w_first_rd  = (r_state == S_RD) & (r_wcnt == 3'd0);
  assign w_fwd_hit   = r_buf_vld & (r_buf_addr == r_addr);

  always_comb begin
    w_merged = mem_rdata;
    for (int i = 0; i < 8; i++) begin
      if (w_fwd_hit && r_buf_wbe[i]) begin
        w_merged[8*i +: 8] = r_buf_data[8*i +: 8];
      end
    end
  end

  // Read data is live from the SRAM in the first data cycle and held afterwards.
  assign HRDATA    = w_first_rd ? w_merged : r_hrdata;
  assign HREADYOUT = w_ready;
  assign HRESP     = 1'b0;

  assign mem_en    = w_rd_accept | w_drain;
  assign mem_we    = w_drain;
  assign mem_addr  = w_rd_accept ? w_haddr_word : r_buf_addr;
  assign mem_wbe   = w_drain ? r_buf_wbe : 8'h00;
  assign mem_wdata = r_buf_data;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_lanes    <= 8'h00;
      r_wcnt     <= 3'd0;
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_wbe  <= 8'h00;
      r_buf_data <= 64'd0;
      r_hrdata   <= 64'd0;
    end else begin
      if (w_accept) begin
        r_state <= HWRITE ? S_WR : S_RD;
        r_addr  <= w_haddr_word;
        r_lanes <= w_lanes;
      end else if (w_ready) begin
        r_state <= S_IDLE;
      end

      // Counter holds at the final value during a full-buffer stall.
      if (w_ready || w_accept) begin
        r_wcnt <= 3'd0;
      end else if (!w_final) begin
        r_wcnt <= r_wcnt + 3'd1;
      end

      // A capture at the same edge as a drain simply replaces the drained entry.
      if (w_capture) begin
        r_buf_vld  <= 1'b1;
        r_buf_addr <= r_addr;
        r_buf_wbe  <= r_lanes;
        r_buf_data <= HWDATA;
      end else if (w_drain) begin
        r_buf_vld  <= 1'b0;
      end

      if (w_first_rd) begin
        r_hrdata <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_sram64_slave.sv
module tb_ahbl_sram64_slave;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wbe;
    logic [63:0] wdata;
  } mem_op_t;

  logic        HCLK = 1'b0;
  logic        HRESET;

  // Instance with WAIT_STATES=0
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA, HRDATA;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wbe;
  logic [63:0] mem_wdata, mem_rdata;

  // Instance with WAIT_STATES=2
  logic        b_hsel, b_hwrite, b_hready, b_hreadyout, b_hresp;
  logic [31:0] b_haddr;
  logic [1:0]  b_htrans;
  logic [2:0]  b_hsize;
  logic [63:0] b_hwdata, b_hrdata;
  logic        b_mem_en, b_mem_we;
  logic [11:0] b_mem_addr;
  logic [7:0]  b_mem_wbe;
  logic [63:0] b_mem_wdata, b_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_op_t     exp_mem[$];
  logic [63:0] exp_rd[$];

  always #5 HCLK = ~HCLK;

  // Single-slave bus: the decoder's HREADY is this slave's HREADYOUT.
  assign HREADY   = HREADYOUT;
  assign b_hready = b_hreadyout;

  ahbl_sram64_slave #(.AW(12), .WAIT_STATES(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wbe(mem_wbe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ahbl_sram64_slave #(.AW(12), .WAIT_STATES(2)) dut_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(b_hsel), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HWRITE(b_hwrite), .HSIZE(b_hsize), .HREADY(b_hready), .HWDATA(b_hwdata),
    .HREADYOUT(b_hreadyout), .HRDATA(b_hrdata), .HRESP(b_hresp),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wbe(b_mem_wbe),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // SRAM models: unwritten words read as 0xC0DE0000_0000_0000 | word index.
  function automatic logic [63:0] pat(input logic [11:0] a);
    return 64'hC0DE_0000_0000_0000 | {52'd0, a};
  endfunction

  logic [63:0] sram0 [0:4095];
  bit          wr0   [0:4095];
  logic [63:0] sram1 [0:4095];
  bit          wr1   [0:4095];

  always @(posedge HCLK) begin
    if (mem_en) begin : m0
      logic [63:0] cur;
      cur = wr0[mem_addr] ? sram0[mem_addr] : pat(mem_addr);
      if (mem_we) begin
        for (int i = 0; i < 8; i++)
          if (mem_wbe[i]) cur[8*i +: 8] = mem_wdata[8*i +: 8];
        sram0[mem_addr] <= cur;
        wr0[mem_addr]   <= 1'b1;
      end else begin
        mem_rdata <= cur;
      end
    end
  end

  always @(posedge HCLK) begin
    if (b_mem_en) begin : m1
      logic [63:0] cur;
      cur = wr1[b_mem_addr] ? sram1[b_mem_addr] : pat(b_mem_addr);
      if (b_mem_we) begin
        for (int i = 0; i < 8; i++)
          if (b_mem_wbe[i]) cur[8*i +: 8] = b_mem_wdata[8*i +: 8];
        sram1[b_mem_addr] <= cur;
        wr1[b_mem_addr]   <= 1'b1;
      end else begin
        b_mem_rdata <= cur;
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic exp_op(input logic we, input logic [11:0] a, input logic [7:0] wbe, input logic [63:0] wd);
    mem_op_t op;
    op.we = we; op.addr = a; op.wbe = wbe; op.wdata = wd;
    exp_mem.push_back(op);
  endtask

  // Monitor: every SRAM access and every completed read data phase is popped
  // against the expectation queues filled by the stimulus.
  logic rd_dp = 1'b0;
  always @(negedge HCLK) begin
    if (HRESET) begin
      rd_dp = 1'b0;
    end else begin
      if (mem_en) begin
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got access we=%0b addr=0x%0h wbe=0x%0h, expected none", mem_we, mem_addr, mem_wbe);
        end else begin : pop_op
          mem_op_t e;
          e = exp_mem.pop_front();
          chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
          chk("mem_addr", {52'd0, mem_addr}, {52'd0, e.addr});
          if (e.we) begin
            chk("mem_wbe", {56'd0, mem_wbe}, {56'd0, e.wbe});
            chk("mem_wdata", mem_wdata, e.wdata);
          end
        end
      end
      if (HREADYOUT) begin
        if (rd_dp) begin
          if (exp_rd.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL hrdata_unexpected: got read completion 0x%0h, expected none", HRDATA);
          end else begin
            chk("hrdata", HRDATA, exp_rd.pop_front());
          end
        end
        rd_dp = HSEL && HTRANS[1] && !HWRITE;
      end
    end
  end

  // One AHB pipeline step: present an address phase (and HWDATA for the
  // previous transfer), then wait until HREADY is high at a clock edge.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [63:0] wd, output int waits);
    logic rdy;
    int   cyc;
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HWDATA = wd;
    waits = 0; cyc = 0;
    do begin
      @(negedge HCLK); rdy = HREADYOUT;
      @(posedge HCLK); #1;
      if (!rdy) waits++;
      cyc++;
    end while (!rdy && cyc < 16);
    if (!rdy) begin
      n_checks++; n_fail++;
      $display("FAIL hready_timeout: got HREADYOUT=0 for %0d cycles, expected 1", cyc);
    end
  endtask

  task automatic idle(input logic [63:0] wd);
    int w;
    step(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, wd, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int w, wsum;
    logic [2:0] rdy_pat;
    HRESET = 1'b1;
    HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 0; HWDATA = 0;
    b_hsel = 0; b_htrans = 0; b_hwrite = 0; b_haddr = 0; b_hsize = 0; b_hwdata = 0;
    repeat (2) @(posedge HCLK);
    #1;
    // Reset state, including an attempted read while reset is held
    chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    chk("rst_hrdata", HRDATA, 64'd0);
    chk("rst_hresp", {63'd0, HRESP}, 64'd0);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h2000_0008; HSIZE = 3;
    #1;
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_wbe", {56'd0, mem_wbe}, 64'd0);
    HSEL = 0; HTRANS = 0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // 1: dword write, drain, read back
    wsum = 0;
    exp_op(1, 12'd1, 8'hFF, 64'h1122_3344_5566_7788);
    step(1, 2'b10, 1, 32'h2000_0008, 3'd3, 64'd0, w); wsum += w;
    step(0, 2'b00, 0, 32'h0, 3'd0, 64'h1122_3344_5566_7788, w); wsum += w;
    step(0, 2'b00, 0, 32'h0, 3'd0, 64'd0, w); wsum += w;
    step(0, 2'b00, 0, 32'h0, 3'd0, 64'd0, w); wsum += w;
    exp_op(0, 12'd1, 8'h00, 64'd0);
    exp_rd.push_back(64'h1122_3344_5566_7788);
    step(1, 2'b10, 0, 32'h2000_0008, 3'd3, 64'd0, w); wsum += w;
    step(0, 2'b00, 0, 32'h0, 3'd0, 64'd0, w); wsum += w;
    chk("t1_waits", 64'(wsum), 64'd0);

    // 2: byte write then overlapped word read of the same dword (forwarding)
    exp_op(0, 12'd2, 8'h00, 64'd0);
    exp_op(1, 12'd2, 8'h08, 64'hFFFF_FFFF_ABFF_FFFF);
    exp_rd.push_back(64'hC0DE_0000_AB00_0002);
    step(1, 2'b10, 1, 32'h2000_0013, 3'd0, 64'd0, w);
    step(1, 2'b10, 0, 32'h2000_0010, 3'd2, 64'hFFFF_FFFF_ABFF_FFFF, w);
    chk("t2_waits", 64'(w), 64'd0);
    idle(64'd0);
    idle(64'd0);

    // 3: write A, write B, read C back-to-back -> one stall cycle on B
    exp_op(1, 12'd32, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
    exp_op(0, 12'd34, 8'h00, 64'd0);
    exp_op(1, 12'd33, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB);
    exp_rd.push_back(64'hC0DE_0000_0000_0022);
    step(1, 2'b10, 1, 32'h2000_0100, 3'd3, 64'd0, w);
    step(1, 2'b10, 1, 32'h2000_0108, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, w);
    chk("t3_waits_a", 64'(w), 64'd0);
    step(1, 2'b10, 0, 32'h2000_0110, 3'd3, 64'hBBBB_BBBB_BBBB_BBBB, w);
    chk("t3_waits_b", 64'(w), 64'd1);
    idle(64'd0);
    idle(64'd0);

    // 4: WAIT_STATES=2 read and write
    rdy_pat = 3'b100;
    b_hsel = 1; b_htrans = 2'b10; b_hwrite = 0; b_haddr = 32'h2000_0018; b_hsize = 3;
    @(posedge HCLK); #1;
    b_hsel = 0; b_htrans = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_rd_ready_%0d", k), {63'd0, b_hreadyout}, {63'd0, rdy_pat[k]});
      chk($sformatf("t4_rd_data_%0d", k), b_hrdata, 64'hC0DE_0000_0000_0003);
      @(posedge HCLK); #1;
    end
    b_hsel = 1; b_htrans = 2'b10; b_hwrite = 1; b_haddr = 32'h2000_0020; b_hsize = 3;
    @(posedge HCLK); #1;
    b_hsel = 0; b_htrans = 0; b_hwrite = 0; b_hwdata = 64'hFEED_FACE_0123_4567;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_wr_ready_%0d", k), {63'd0, b_hreadyout}, {63'd0, rdy_pat[k]});
      chk($sformatf("t4_wr_noacc_%0d", k), {63'd0, b_mem_en}, 64'd0);
      @(posedge HCLK); #1;
    end
    chk("t4_drain_en", {63'd0, b_mem_en}, 64'd1);
    chk("t4_drain_we", {63'd0, b_mem_we}, 64'd1);
    chk("t4_drain_addr", {52'd0, b_mem_addr}, 64'd4);
    chk("t4_drain_wbe", {56'd0, b_mem_wbe}, 64'hFF);
    chk("t4_drain_wdata", b_mem_wdata, 64'hFEED_FACE_0123_4567);
    chk("t4_hresp", {63'd0, b_hresp}, 64'd0);
    @(posedge HCLK); #1;
    chk("t4_drain_once", {63'd0, b_mem_en}, 64'd0);

    // 5: IDLE with HSEL, NONSEQ without HSEL, then address aliasing
    HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'h2000_0008; HSIZE = 3;
    #2;
    chk("t5_idle_en", {63'd0, mem_en}, 64'd0);
    chk("t5_idle_rdy", {63'd0, HREADYOUT}, 64'd1);
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b10; HWRITE = 0;
    #2;
    chk("t5_nosel_en", {63'd0, mem_en}, 64'd0);
    chk("t5_nosel_rdy", {63'd0, HREADYOUT}, 64'd1);
    @(posedge HCLK); #1;
    exp_op(0, 12'd1, 8'h00, 64'd0);
    exp_op(1, 12'd1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    exp_rd.push_back(64'h0123_4567_89AB_CDEF);
    step(1, 2'b10, 1, 32'h2000_8008, 3'd3, 64'd0, w);
    step(1, 2'b10, 0, 32'h2000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, w);
    idle(64'd0);
    idle(64'd0);

    // 6: reset while the buffer holds an undrained write
    step(1, 2'b10, 1, 32'h2000_0028, 3'd3, 64'd0, w);
    step(0, 2'b00, 0, 32'h0, 3'd0, 64'hDEAD_BEEF_DEAD_BEEF, w);
    HRESET = 1'b1;
    #1;
    chk("t6_rst_rdy", {63'd0, HREADYOUT}, 64'd1);
    chk("t6_rst_hrdata", HRDATA, 64'd0);
    chk("t6_rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("t6_rst_mem_we", {63'd0, mem_we}, 64'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    exp_op(0, 12'd5, 8'h00, 64'd0);
    exp_rd.push_back(64'hC0DE_0000_0000_0005);
    step(1, 2'b10, 0, 32'h2000_0028, 3'd3, 64'd0, w);
    idle(64'd0);
    repeat (3) idle(64'd0);

    chk("left_mem_ops", 64'(exp_mem.size()), 64'd0);
    chk("left_reads", 64'(exp_rd.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_sram64_slave.md
Name: ahbl_sram64_slave

Overview:
AHB-lite slave for one 64-bit bus slot. It responds to a bus decoder that supplies HSEL, HREADY and HTRANS, and it fronts a single-port synchronous SRAM with a 1-cycle read latency. Writes are posted through a one-entry write buffer, and reads that hit the buffer are forwarded from it. The number of data-phase wait states is configurable.

Parameters:
AW, 12, SRAM word-address width; the SRAM holds 2^AW 64-bit words.
WAIT_STATES, 0, extra data-phase cycles (HREADYOUT=0) added to every read and every write; legal range 0..7.

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slot select from the decoder
HADDR  in  32  address-phase address
HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word, 3 = dword
HREADY  in  1  bus-level ready; qualifies acceptance of the address phase
HWDATA  in  64  write data, valid in the data phase
HREADYOUT  out  1  slave ready
HRDATA  out  64  read data
HRESP  out  1  tied to 0 (OKAY)
mem_en  out  1  SRAM access strobe
mem_we  out  1  1 = SRAM write
mem_addr  out  AW  SRAM word address (HADDR[AW+2:3] for reads, buffer address for drains)
mem_wbe  out  8  byte write enables
mem_wdata  out  64  SRAM write data
mem_rdata  in  64  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset is asynchronous and active-high. Reset values: HREADYOUT=1, HRDATA=0, write buffer invalid, wait counter 0, FSM in IDLE. mem_en, mem_we and mem_wbe are 0 while reset is asserted.
- Accept: accept = HSEL & HREADY & HTRANS[1]. On accept, latch the address, HWRITE and HSIZE.
- IDLE/BUSY transfers, and cycles with HSEL low, complete with zero wait and cause no SRAM access.
- Byte lanes: computed from HSIZE and HADDR[2:0], aligned down to the transfer size.
  - byte: 1 lane.
  - half: lanes {2k, 2k+1}.
  - word: lanes 0-3 or 4-7.
  - dword: all 8 lanes.
  - Misalignment is not flagged. HSIZE > 3 is treated as dword.
- Address wrap: HADDR bits above AW+2 are ignored, so addresses alias modulo 2^AW words.
- FSM states: IDLE, RD, WR.
  - IDLE -> RD on an accepted read; IDLE -> WR on an accepted write.
  - RD/WR -> RD/WR/IDLE on the final data-phase cycle, according to the accept condition in that cycle.
- Read:
  - In the accept cycle, combinationally drive mem_en=1, mem_we=0, mem_addr = word address.
  - First data-phase cycle: HRDATA register <= mem_rdata, with forwarding applied.
  - HREADYOUT=0 for WAIT_STATES cycles, then 1.
  - Read data-phase length is 1+WAIT_STATES cycles. HRDATA holds its value until the next read.
- Forwarding: applied in the first read data-phase cycle. If the buffer is valid and its address equals the latched read address, every lane with buffer wbe=1 is taken from the buffer; the other lanes come from mem_rdata.
- Write:
  - Data phase lasts 1+WAIT_STATES cycles.
  - At the edge ending the final data-phase cycle (HREADYOUT=1), the buffer captures {address, HWDATA, lanes} and becomes valid.
- Drain: in any cycle where the buffer is valid and no read is being accepted, drive mem_en=1, mem_we=1, mem_addr/mem_wbe/mem_wdata from the buffer. The buffer becomes invalid at that edge, unless a new write is captured at the same edge, in which case the new write replaces it.
- Buffer-full stall: if in the final write data-phase cycle the buffer is valid and the drain is blocked, force HREADYOUT=0 for that cycle. A cycle with HREADYOUT=0 cannot accept a read, so the drain proceeds, and HREADYOUT returns to 1 the following cycle. The stall costs one cycle.
- Priority: an accepted read beats a drain. A read and a drain never issue in the same cycle.
- Reset mid-operation discards any buffered write and any in-flight transfer.

Test Plan:
1. WAIT_STATES=0: write dword 0x1122334455667788 to 0x20000008, then IDLE for 2 cycles -> one mem_we pulse with wbe=0xFF and addr=1; a later read of 0x20000008 returns 0x1122334455667788 with HREADYOUT always 1.
2. Byte write 0xAB to 0x20000013, then an immediate read of 0x20000010 (the read address phase overlaps the write data phase) -> HRDATA[31:24]=0xAB with the other lanes from SRAM (forwarded); the drain occurs in the read data-phase cycle.
3. Write A, write B, then read C back-to-back -> the data phase of B shows exactly one HREADYOUT=0 cycle; the SRAM sees write A, read C, write B in that order; read C data is correct.
4. WAIT_STATES=2: a read shows HREADYOUT pattern 0,0,1 and HRDATA stable from the first data cycle; a write shows the same pattern with the buffer captured at the 3rd edge.
5. HSEL=1 with HTRANS=IDLE, and HSEL=0 with HTRANS=NONSEQ -> no mem_en and HREADYOUT=1; address 0x20008008 with AW=12 aliases to word 1.
6. Assert HRESET with the buffer valid -> HREADYOUT=1 and HRDATA=0 immediately, and no SRAM write ever issues for the discarded entry.
